serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller: sequences one `full_adder` instance over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in.
- Provides a start/busy/done handshake for an area-minimal multi-bit add built from the existing 1-bit full adder cell.
- Sits between a requesting datapath and the `full_adder` cell; owns operand shifting, carry storage and bit counting.

---
 rtl/serial_adder_ctrl_pkg.sv | 18 +
 rtl/serial_adder_ctrl_full_adder.sv | 16 +
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    // Default operand width when the parent does not override it.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Legal operand width range.
    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    // Controller states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell; purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic carry
);

    // Sum is the three-way parity, carry is the majority.
    always_comb begin
        sum   = a ^ b ^ ci;
        carry = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: steps one full_adder over WIDTH cycles,
// LSB first, with a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Reject illegal widths at elaboration.
    generate
        if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH out of range");
        end
    endgenerate

    state_e           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic fa_sum;
    logic fa_carry;

    // Single shared adder cell fed from the operand LSBs and the carry flop.
    full_adder u_fa (
        .a     (sa[0]),
        .b     (sb[0]),
        .ci    (c),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // FSM, operand/result shifting, carry, bit counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                // IDLE and DONE accept a new request identically.
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        sr    <= '0;
                        c     <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                // One result bit per cycle; sum/cout only move on the final bit.
                S_RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    sr  <= {fa_sum, sr[WIDTH-1:1]};
                    c   <= fa_carry;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= {fa_sum, sr[WIDTH-1:1]};
                        cout  <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 directed, WIDTH=4 exhaustive).
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int n_cmp;
    int n_bad;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      nm;
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    // One full WIDTH=8 operation: latency, busy length, hold, result, single pulse.
    task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tc, input logic [7:0] es, input logic ec);
        logic [7:0] prev_s;
        logic       prev_c;
        int cyc;
        int bcyc;
        bit held;
        bit overlap;
        prev_s = sum;
        prev_c = cout;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'hA5; b = 8'h5A; cin = 1'b1;
        cyc = 0; bcyc = 0; held = 1'b1; overlap = 1'b0;
        while (!done && cyc < 40) begin
            if (busy) bcyc++;
            if (sum !== prev_s || cout !== prev_c) held = 1'b0;
            tick();
            cyc++;
        end
        if (busy && done) overlap = 1'b1;
        check({nm, "_latency"}, 32'(cyc), 32'd8);
        check({nm, "_busy_cycles"}, 32'(bcyc), 32'd8);
        check({nm, "_held_in_run"}, 32'(held), 32'd1);
        check({nm, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check({nm, "_sum"}, 32'(sum), 32'(es));
        check({nm, "_cout"}, 32'(cout), 32'(ec));
        tick();
        check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int cyc;
        int pulses;
        logic [4:0] exp5;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{"v5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{"vff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{"vff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{"v10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[4] = '{"v80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{"v00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{"vaa_55_c", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        #2 rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].nm, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec);
        end

        // Start pulsed during RUN must be ignored.
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 3; pulses = 0;
        while (cyc < 30) begin
            if (done) pulses++;
            if (done) check("ign_sum", 32'(sum), 32'h30);
            if (done) check("ign_cout", 32'(cout), 32'd0);
            if (done) check("ign_latency", 32'(cyc), 32'd8);
            tick();
            cyc++;
        end
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_busy_after", 32'(busy), 32'd0);

        // Back-to-back: start held through DONE launches the second op.
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'h02; b = 8'h03;
        cyc = 0;
        while (!done && cyc < 40) begin tick(); cyc++; end
        check("b2b_first_latency", 32'(cyc), 32'd8);
        check("b2b_first_sum", 32'(sum), 32'h02);
        cyc = 0;
        tick();
        check("b2b_rerun_busy", 32'(busy), 32'd1);
        cyc++;
        start = 1'b0;
        while (!done && cyc < 40) begin tick(); cyc++; end
        check("b2b_pulse_spacing", 32'(cyc), 32'd9);
        check("b2b_second_sum", 32'(sum), 32'h05);
        check("b2b_second_cout", 32'(cout), 32'd0);
        tick();

        // Asynchronous reset in RUN cycle 4.
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("ar_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_sum", 32'(sum), 32'd0);
        check("ar_cout", 32'(cout), 32'd0);
        #1 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("ar_no_activity", 32'(pulses), 32'd0);
        run_op("after_reset", 8'h07, 8'h09, 1'b0, 8'h10, 1'b0);

        // WIDTH=4 exhaustive sweep.
        for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    exp5 = 5'(ia) + 5'(ib) + 5'(ci);
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ci); start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    cyc = 0;
                    while (!done4 && cyc < 20) begin tick(); cyc++; end
                    check($sformatf("w4_lat_%0d_%0d_%0d", ia, ib, ci), 32'(cyc + 1), 32'd5);
                    check($sformatf("w4_res_%0d_%0d_%0d", ia, ib, ci), 32'({cout4, sum4}), 32'(exp5));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
